// File: rtl/pixel_pkg.sv
// Shared pixel/raster constants for the distributor, engines and collector.
package pixel_pkg;
   localparam int SCREEN_WIDTH     = 640;
   localparam int SCREEN_HEIGHT    = 480;
   localparam int NUM_ENGINES      = 30;
   localparam int COLOUR_WIDTH     = 24;
   localparam int PIXEL_DATA_WIDTH = COLOUR_WIDTH;

   typedef logic [COLOUR_WIDTH-1:0] colour_t;
endpackage

// File: rtl/raster_position_counter.sv
// Raster x/y tracker: one pixel per advance, wrapping at line and frame end.
module raster_position_counter
   import pixel_pkg::*;
#(
   parameter int WIDTH  = SCREEN_WIDTH,
   parameter int HEIGHT = SCREEN_HEIGHT
) (
   input  logic clk,
   input  logic reset,
   input  logic adv_i,
   output logic eol_o,
   output logic sof_o
);
   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

   assign eol_o = (x_q == XW'(WIDTH - 1));
   assign sof_o = (x_q == '0) && (y_q == '0);

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (adv_i) begin
         if (eol_o) begin
            x_d = '0;
            y_d = (y_q == YW'(HEIGHT - 1)) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end
endmodule

// File: rtl/result_collector.sv
// Collects one result per engine into a capture bank, hands full batches to
// an output bank and streams them in raster order toward the frame writer.
module result_collector
   import pixel_pkg::*;
#(
   parameter int SW = SCREEN_WIDTH,
   parameter int SH = SCREEN_HEIGHT
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic [NUM_ENGINES-1:0]                    eng_valid,
   input  logic [NUM_ENGINES-1:0][COLOUR_WIDTH-1:0]  eng_result,
   output logic                                      fin_flag,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic [COLOUR_WIDTH-1:0]                   out_data,
   output logic                                      out_last,
   output logic                                      out_user,
   output logic                                      overrun
);
   localparam int N  = NUM_ENGINES;
   localparam int IW = $clog2(N);

   logic [N-1:0]  cap_q, cap_d;
   colour_t       cap_bank_q [N];
   colour_t       out_bank_q [N];
   logic [IW-1:0] idx_q, idx_d;
   logic          valid_q, valid_d;
   logic          fin_q;
   logic          ovr_q, ovr_d;
   logic          hs, last_beat, xfer;
   logic          eol, sof;

   assign hs        = valid_q & out_ready;
   assign last_beat = (idx_q == IW'(N - 1));
   // Final handshake frees the output bank on the same edge, so no bubble.
   assign xfer      = (&cap_q) & (~valid_q | (last_beat & hs));

   always_comb begin
      cap_d   = xfer ? eng_valid : (cap_q | eng_valid);
      ovr_d   = ovr_q | (|(eng_valid & cap_q & {N{~xfer}}));
      idx_d   = idx_q;
      valid_d = valid_q;
      if (xfer) begin
         idx_d   = '0;
         valid_d = 1'b1;
      end else if (hs) begin
         idx_d   = last_beat ? '0 : idx_q + 1'b1;
         valid_d = ~last_beat;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         fin_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         cap_q   <= cap_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         fin_q   <= xfer;
         ovr_q   <= ovr_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (eng_valid[i] & (xfer | ~cap_q[i])) begin
            cap_bank_q[i] <= eng_result[i];
         end
      end
      if (xfer) begin
         out_bank_q <= cap_bank_q;
      end
   end

   raster_position_counter #(
      .WIDTH  (SW),
      .HEIGHT (SH)
   ) u_raster (
      .clk   (clk),
      .reset (reset),
      .adv_i (hs),
      .eol_o (eol),
      .sof_o (sof)
   );

   assign fin_flag  = fin_q;
   assign out_valid = valid_q;
   assign out_data  = valid_q ? out_bank_q[idx_q] : '0;
   assign out_last  = valid_q & eol;
   assign out_user  = sof;
   assign overrun   = ovr_q;
endmodule
